// File: rtl/pipe_hazard_if.sv
// Pipeline-side bundle for the stall/flush controller.
// Pipeline stages drive the hazard fields through the master modport; the
// controller consumes them and returns the enables through the slave modport.
// Optional macro HAZARD_STATS_EN adds the stall statistics counters.
interface pipe_hazard_if;
  // D-stage operand usage
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_rs_tuse;
  logic [1:0] d_rt_tuse;
  logic       d_is_md;
  // Producers in E and M
  logic [4:0] e_wa;
  logic [1:0] e_tnew;
  logic [4:0] m_wa;
  logic [1:0] m_tnew;
  // Multiply/divide launch from E
  logic       e_md_start;
  logic       e_md_is_div;
  // Controller results
  logic       f_we;
  logic       d_we;
  logic       e_flush;
  logic       md_busy;
  logic       stall;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] md_stall_cnt;

  modport master (
    output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_is_md,
    output e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_is_div,
    input  f_we, d_we, e_flush, md_busy, stall, stall_cnt, md_stall_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_is_md,
    input  e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_is_div,
    output f_we, d_we, e_flush, md_busy, stall, stall_cnt, md_stall_cnt
  );
`else
  modport master (
    output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_is_md,
    output e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_is_div,
    input  f_we, d_we, e_flush, md_busy, stall
  );

  modport slave (
    input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_is_md,
    input  e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_is_div,
    output f_we, d_we, e_flush, md_busy, stall
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage MIPS pipeline.
// Stalls D on Tuse/Tnew read-after-write hazards against E and M, and on any
// MD-class instruction while the multiply/divide unit is busy or starting.
// A stall freezes PC and F/D and injects a bubble into D/E in the same cycle.
// Optional macro HAZARD_STATS_EN adds stall_cnt / md_stall_cnt counters.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,   // busy cycles after a mult/multu start (1..15)
  parameter int DIV_CYC  = 10   // busy cycles after a div/divu start (1..15)
) (
  input logic          clk,
  input logic          reset,
  pipe_hazard_if.slave hz
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  logic [3:0] md_cnt;
  logic       rs_stall;
  logic       rt_stall;
  logic       md_stall;
  logic       stall_raw;

  // A source register stalls when a younger-needed value is produced too late
  // for forwarding; Tnew == Tuse is covered by the bypass network.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (src == e_wa) && (e_tnew > tuse);
    m_hit = (src == m_wa) && (m_tnew > tuse);
    return (src != 5'd0) && (e_hit || m_hit);
  endfunction

  // Hazard detection, purely combinational from the stage fields
  always_comb begin
    rs_stall  = src_hazard(hz.d_rs, hz.d_rs_tuse, hz.e_wa, hz.e_tnew,
                           hz.m_wa, hz.m_tnew);
    rt_stall  = src_hazard(hz.d_rt, hz.d_rt_tuse, hz.e_wa, hz.e_tnew,
                           hz.m_wa, hz.m_tnew);
    // The start cycle itself already blocks a following MD instruction
    md_stall  = hz.d_is_md && (hz.md_busy || hz.e_md_start);
    stall_raw = rs_stall || rt_stall || md_stall;
  end

  // Pipeline enables; reset forces the pipe to advance freely
  always_comb begin
    hz.stall   = stall_raw && !reset;
    hz.f_we    = !hz.stall;
    hz.d_we    = !hz.stall;
    hz.e_flush = hz.stall;
  end

  // MD busy counter: load on an idle start, otherwise count down to zero.
  // A start while busy cannot legally happen and is ignored. The start is
  // honoured even when D/E is flushed: it belongs to the instruction in E.
  always_ff @(posedge clk) begin
    if (reset)
      md_cnt <= 4'd0;
    else if (hz.e_md_start && (md_cnt == 4'd0))
      md_cnt <= hz.e_md_is_div ? DIV_LOAD : MULT_LOAD;
    else if (md_cnt != 4'd0)
      md_cnt <= md_cnt - 4'd1;
  end

  assign hz.md_busy = (md_cnt != 4'd0);

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] md_stall_cnt_q;

  // Statistics: count stalled cycles overall and those caused by the MD unit
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= 32'd0;
      md_stall_cnt_q <= 32'd0;
    end else begin
      if (stall_raw) stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (md_stall)  md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: data hazards, MD sequencing, reset.
// Inputs change just after the falling edge and outputs are sampled 2 time
// units later, well before the next rising edge.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  pipe_hazard_if hz ();

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Check the full stall output group against one expected stall value
  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, ".stall"},   32'(hz.stall),   32'(exp));
    chk({tag, ".f_we"},    32'(hz.f_we),    32'(!exp));
    chk({tag, ".d_we"},    32'(hz.d_we),    32'(!exp));
    chk({tag, ".e_flush"}, 32'(hz.e_flush), 32'(exp));
  endtask

  task automatic idle();
    hz.d_rs = 5'd0; hz.d_rt = 5'd0;
    hz.d_rs_tuse = 2'd3; hz.d_rt_tuse = 2'd3;
    hz.d_is_md = 1'b0;
    hz.e_wa = 5'd0; hz.e_tnew = 2'd0;
    hz.m_wa = 5'd0; hz.m_tnew = 2'd0;
    hz.e_md_start = 1'b0; hz.e_md_is_div = 1'b0;
  endtask

  // Advance to the next falling edge (input change point)
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    idle();
    nxt();
    // Reset with a load-use hazard on the inputs: pipe must still advance
    hz.e_wa = 5'd8; hz.e_tnew = 2'd2; hz.d_rs = 5'd8; hz.d_rs_tuse = 2'd1;
    settle();
    chk_stall("rst_hazard", 1'b0);
    chk("rst_busy", 32'(hz.md_busy), 32'd0);
    nxt();
    reset = 1'b0;

    // Load-use hazard against E
    settle();
    chk_stall("load_use", 1'b1);
    // Tnew == Tuse is forwarded
    hz.d_rs_tuse = 2'd2;
    settle();
    chk_stall("tnew_eq_tuse", 1'b0);

    // Register 0 never stalls
    nxt(); idle();
    hz.e_wa = 5'd0; hz.d_rs = 5'd0; hz.e_tnew = 2'd2; hz.d_rs_tuse = 2'd0;
    settle();
    chk("reg0", 32'(hz.stall), 32'd0);

    // M-stage hazard on rt
    nxt(); idle();
    hz.m_wa = 5'd5; hz.m_tnew = 2'd1; hz.d_rt = 5'd5; hz.d_rt_tuse = 2'd0;
    settle();
    chk_stall("m_rt", 1'b1);
    // Same M producer but consumer needs it later: no stall
    hz.d_rt_tuse = 2'd1;
    settle();
    chk("m_rt_late", 32'(hz.stall), 32'd0);
    // rt against E with a different rs in M that is not matched
    nxt(); idle();
    hz.e_wa = 5'd17; hz.e_tnew = 2'd1; hz.d_rt = 5'd17; hz.d_rt_tuse = 2'd0;
    hz.m_wa = 5'd3; hz.m_tnew = 2'd2; hz.d_rs = 5'd4; hz.d_rs_tuse = 2'd0;
    settle();
    chk("e_rt", 32'(hz.stall), 32'd1);
    hz.d_rt = 5'd18;
    settle();
    chk("no_match", 32'(hz.stall), 32'd0);

    // Mult sequencing with an MD instruction waiting in D
    nxt(); idle();
    hz.d_is_md = 1'b1; hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b0;
    settle();
    chk("mult_start_stall", 32'(hz.stall), 32'd1);
    chk("mult_start_busy", 32'(hz.md_busy), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      nxt();
      hz.e_md_start = 1'b0;
      settle();
      chk($sformatf("mult_busy_%0d", i), 32'(hz.md_busy), 32'd1);
      chk($sformatf("mult_stall_%0d", i), 32'(hz.stall), 32'd1);
    end
    nxt(); settle();
    chk("mult_done_busy", 32'(hz.md_busy), 32'd0);
    chk_stall("mult_done", 1'b0);

    // Div sequencing with a non-MD instruction in D: never stalls
    nxt(); idle();
    hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b1;
    settle();
    chk("div_start_stall", 32'(hz.stall), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      nxt();
      hz.e_md_start = 1'b0;
      settle();
      chk($sformatf("div_busy_%0d", i), 32'(hz.md_busy), 32'd1);
      chk($sformatf("div_nomd_%0d", i), 32'(hz.stall), 32'd0);
    end
    nxt(); settle();
    chk("div_done_busy", 32'(hz.md_busy), 32'd0);

    // Data hazard and MD stall together give one ordinary stall
    nxt(); idle();
    hz.d_is_md = 1'b1; hz.e_md_start = 1'b1;
    hz.e_wa = 5'd9; hz.e_tnew = 2'd2; hz.d_rs = 5'd9; hz.d_rs_tuse = 2'd0;
    settle();
    chk_stall("both", 1'b1);
    // Start is honoured despite the flush; a second start while busy is ignored
    nxt();
    settle();
    chk("flush_start_busy", 32'(hz.md_busy), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      nxt(); idle();
      settle();
    end
    chk("ignored_restart", 32'(hz.md_busy), 32'd1);
    nxt(); settle();
    chk("ignored_restart_end", 32'(hz.md_busy), 32'd0);

    // Reset in the middle of a divide
    nxt(); idle();
    hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      nxt(); hz.e_md_start = 1'b0;
    end
    reset = 1'b1;
    hz.d_is_md = 1'b1;
    hz.e_wa = 5'd8; hz.e_tnew = 2'd2; hz.d_rs = 5'd8; hz.d_rs_tuse = 2'd1;
    settle();
    chk("rst_mid_busy_pre", 32'(hz.md_busy), 32'd1);
    chk_stall("rst_mid", 1'b0);
    nxt(); settle();
    chk("rst_mid_busy_post", 32'(hz.md_busy), 32'd0);
    chk_stall("rst_mid2", 1'b0);
    nxt();
    reset = 1'b0;
    idle();

`ifdef HAZARD_STATS_EN
    // Statistics: 3 load-use stalls plus one mult with a waiting MD instr
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    settle();
    chk("stats_rst_stall", hz.stall_cnt, 32'd0);
    chk("stats_rst_md", hz.md_stall_cnt, 32'd0);
    hz.e_wa = 5'd8; hz.e_tnew = 2'd2; hz.d_rs = 5'd8; hz.d_rs_tuse = 2'd1;
    for (int i = 0; i < 3; i++) nxt();
    idle();
    hz.d_is_md = 1'b1; hz.e_md_start = 1'b1;
    nxt();
    hz.e_md_start = 1'b0;
    for (int i = 0; i < 5; i++) nxt();
    idle();
    settle();
    chk("stats_stall", hz.stall_cnt, 32'd9);
    chk("stats_md", hz.md_stall_cnt, 32'd6);
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    settle();
    chk("stats_clr_stall", hz.stall_cnt, 32'd0);
    chk("stats_clr_md", hz.md_stall_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/flush controller for the five-stage MIPS pipeline.
- Drives the write enables of the PC and the F/D pipeline register, and the flush of the D/E register.
- Detects register read-after-write hazards from the Tuse/Tnew fields supplied by each stage.
- Sequences the multi-cycle multiply/divide unit with an internal busy counter, stalling any MD-class instruction in D while the unit is occupied.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu after start (1..15).
- DIV_CYC, 10, busy cycles for div/divu after start (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- d_rs  in  5  rs field of instruction in D
- d_rt  in  5  rt field of instruction in D
- d_rs_tuse  in  2  cycles until D needs rs (3 = not used)
- d_rt_tuse  in  2  cycles until D needs rt (3 = not used)
- d_is_md  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- e_wa  in  5  destination register of instr in E (0 = none)
- e_tnew  in  2  cycles until E result is ready
- m_wa  in  5  destination register of instr in M (0 = none)
- m_tnew  in  2  cycles until M result is ready
- e_md_start  in  1  E instr starts mult/div this cycle
- e_md_is_div  in  1  qualifies e_md_start: 1 = div, 0 = mult
- f_we  out  1  PC register write enable
- d_we  out  1  F/D register write enable
- e_flush  out  1  load bubble into D/E register
- md_busy  out  1  MD unit occupied
- stall  out  1  overall stall indication

Behaviour:
Reset:
- Synchronous, active-high, on clk rising edge.
- Clears md_cnt to 0, so md_busy=0.
- While reset=1: stall=0, f_we=1, d_we=1, e_flush=0, regardless of other inputs.

Data hazards (combinational from inputs):
- rs_stall = (d_rs!=0) & ((d_rs==e_wa & e_tnew>d_rs_tuse) | (d_rs==m_wa & m_tnew>d_rs_tuse)).
- rt_stall: same form using d_rt and d_rt_tuse.
- Register 0 never stalls.
- Equal Tnew and Tuse does not stall; the forwarding path covers it.

MD hazard:
- md_stall = d_is_md & (md_busy | e_md_start).
- The start cycle itself blocks a following MD instruction.

Stall outputs:
- stall = rs_stall | rt_stall | md_stall.
- f_we = d_we = ~stall; e_flush = stall.
- Same-cycle output; zero-latency decision.

Busy counter md_cnt (4 bits):
- On clk edge, if e_md_start=1 and md_cnt==0: load DIV_CYC if e_md_is_div, else MULT_CYC.
- Else, if md_cnt!=0: decrement by 1.
- md_busy = (md_cnt!=0), registered.
- After a start, md_busy is high for exactly N cycles (MULT_CYC or DIV_CYC) starting the next cycle.
- e_md_start while md_cnt!=0 cannot occur (the instruction was stalled in D). If it does occur, it is ignored and the counter keeps decrementing.
- Counter never wraps below 0.
- Reset during an MD operation clears md_cnt immediately; md_busy=0 the next cycle.

Simultaneous events:
- Data hazard and md_stall together: single stall; outputs identical.
- e_flush asserted while E holds e_md_start: the start is still honoured, because the start belongs to the instruction already in E.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and md_stall_cnt[31:0].
  - stall_cnt increments on every non-reset cycle with stall=1.
  - md_stall_cnt increments on cycles with md_stall=1.
  - Both cleared by reset; both wrap at 2^32 to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use hazard: e_wa=8, e_tnew=2, d_rs=8, d_rs_tuse=1 -> stall=1, f_we=0, d_we=0, e_flush=1. Change d_rs_tuse to 2 -> stall=0.
- Register-0 exemption: e_wa=0, d_rs=0, e_tnew=2, d_rs_tuse=0 -> stall=0. M-stage hazard: m_wa=5, m_tnew=1, d_rt=5, d_rt_tuse=0 -> stall=1.
- Mult sequencing: pulse e_md_start=1, e_md_is_div=0 with d_is_md=1 held -> stall=1 in the start cycle, md_busy=1 for exactly 5 following cycles, stall=0 on the 6th cycle after the start.
- Div sequencing: pulse e_md_start=1, e_md_is_div=1 -> md_busy=1 for 10 cycles. Non-MD instruction in D (d_is_md=0, no data hazard) -> stall=0 throughout.
- Reset mid-divide: reset after cycle 3 of busy -> md_busy=0 the next cycle; stall=0 and f_we=1 while reset is high, even with hazard inputs active.
- HAZARD_STATS_EN defined: run 3 load-use stall cycles plus one mult with a waiting MD instruction -> stall_cnt=9, md_stall_cnt=6. After reset, both counters read 0.
